// File: rtl/adam_pause_seq.sv
// adam_pause_seq
// Sequences pause and reset for one domain's set of targets. One four-phase
// domain pause handshake is turned into ordered per-target pause handshakes
// (pause ascending, resume descending). Per-target reset requests are
// serviced with the target paused around its reset pulse. After power-on
// all targets are held in reset for RST_CYCLES. Missing target acks time
// out after TIMEOUT cycles (0 = wait forever) and set a sticky err bit.
//
// Ports
//   clk            clock
//   rst_n          asynchronous active-low reset
//   dom_pause_req  domain pause request (four-phase)
//   dom_pause_ack  domain pause ack (four-phase)
//   tgt_pause_req  per-target pause request
//   tgt_pause_ack  per-target pause ack
//   tgt_rst_req    per-target single-cycle reset request pulses
//   tgt_rst        per-target active-high reset
//   err            sticky per-target ack timeout flags
//   err_clr        single-cycle pulse clearing all err bits
module adam_pause_seq #(
  parameter int NO_TGTS    = 4,
  parameter int RST_CYCLES = 4,
  parameter int TIMEOUT    = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               dom_pause_req,
  output logic               dom_pause_ack,
  output logic [NO_TGTS-1:0] tgt_pause_req,
  input  logic [NO_TGTS-1:0] tgt_pause_ack,
  input  logic [NO_TGTS-1:0] tgt_rst_req,
  output logic [NO_TGTS-1:0] tgt_rst,
  output logic [NO_TGTS-1:0] err,
  input  logic               err_clr
);

  localparam int CNT_MAX = (RST_CYCLES > TIMEOUT) ? RST_CYCLES : TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = (NO_TGTS > 1) ? $clog2(NO_TGTS) : 1;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(TIMEOUT);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NO_TGTS - 1);
  localparam bit               TO_EN    = (TIMEOUT != 0);

  typedef enum logic [3:0] {
    S_INIT, S_RUN, S_PAUSE, S_PAUSED, S_RST, S_RESUME,
    S_TPAUSE, S_TRST, S_TRESUME
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NO_TGTS-1:0] pend_q, pend_d;
  logic [NO_TGTS-1:0] err_q, err_d;
  logic [NO_TGTS-1:0] tgt_rst_q, tgt_rst_d;
  logic [NO_TGTS-1:0] tgt_pause_req_q, tgt_pause_req_d;
  logic               dom_pause_ack_q, dom_pause_ack_d;

  logic               ack_hi;
  logic               timeout;
  logic [IDX_W-1:0]   low_idx;
  logic [NO_TGTS-1:0] pend_clr;
  logic [NO_TGTS-1:0] err_set;

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [NO_TGTS-1:0] v);
    lowest_idx = '0;
    for (int i = NO_TGTS - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = IDX_W'(i);
    end
  endfunction

  assign ack_hi  = tgt_pause_ack[idx_q];
  assign timeout = TO_EN && (cnt_q == TO_VAL);
  assign low_idx = lowest_idx(pend_q);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    pend_clr = '0;
    err_set  = '0;

    case (state_q)
      S_INIT: begin
        if (cnt_q == RST_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        // Domain pause outranks queued single-target resets.
        if (dom_pause_req) begin
          state_d = S_PAUSE;
          idx_d   = '0;
        end else if (|pend_q) begin
          state_d = S_TPAUSE;
          idx_d   = low_idx;
        end
      end
      S_PAUSE: begin
        if (ack_hi || timeout) begin
          err_set[idx_q] = ~ack_hi;
          if (idx_q == IDX_LAST) state_d = S_PAUSED;
          else                   idx_d   = idx_q + IDX_W'(1);
        end
      end
      S_PAUSED: begin
        // Every target is already paused, so resets go straight to the pulse.
        if (|pend_q) begin
          state_d           = S_RST;
          idx_d             = low_idx;
          pend_clr[low_idx] = 1'b1;
        end else if (!dom_pause_req) begin
          state_d = S_RESUME;
          idx_d   = IDX_LAST;
        end
      end
      S_RST: begin
        if (cnt_q == RST_LAST) state_d = S_PAUSED;
      end
      S_RESUME: begin
        if (!ack_hi || timeout) begin
          err_set[idx_q] = ack_hi;
          if (idx_q == '0) state_d = S_RUN;
          else             idx_d   = idx_q - IDX_W'(1);
        end
      end
      S_TPAUSE: begin
        if (ack_hi || timeout) begin
          err_set[idx_q]  = ~ack_hi;
          pend_clr[idx_q] = 1'b1;
          state_d         = S_TRST;
        end
      end
      S_TRST: begin
        if (cnt_q == RST_LAST) state_d = S_TRESUME;
      end
      S_TRESUME: begin
        if (!ack_hi || timeout) begin
          err_set[idx_q] = ack_hi;
          state_d        = S_RUN;
        end
      end
      default: state_d = S_INIT;
    endcase

    // One counter serves both reset hold and ack timeout; any step restarts it.
    if ((state_d != state_q) || (idx_d != idx_q)) cnt_d = '0;
    else                                          cnt_d = cnt_q + CNT_W'(1);

    // A request arriving on the cycle its pending bit clears is kept.
    pend_d = (pend_q & ~pend_clr) | tgt_rst_req;
    err_d  = (err_q & ~{NO_TGTS{err_clr}}) | err_set;

    // Outputs are decoded from the next state so they leave a flop.
    tgt_rst_d       = '0;
    tgt_pause_req_d = '0;
    dom_pause_ack_d = 1'b0;
    case (state_d)
      S_INIT: begin
        tgt_rst_d       = '1;
        tgt_pause_req_d = '1;
      end
      S_PAUSE: begin
        for (int j = 0; j < NO_TGTS; j++) tgt_pause_req_d[j] = (j <= int'(idx_d));
      end
      S_PAUSED: begin
        tgt_pause_req_d = '1;
        dom_pause_ack_d = 1'b1;
      end
      S_RST: begin
        tgt_pause_req_d  = '1;
        dom_pause_ack_d  = 1'b1;
        tgt_rst_d[idx_d] = 1'b1;
      end
      S_RESUME: begin
        // Targets above idx are already released; ack holds until RUN.
        for (int j = 0; j < NO_TGTS; j++) tgt_pause_req_d[j] = (j < int'(idx_d));
        dom_pause_ack_d = 1'b1;
      end
      S_TPAUSE: begin
        tgt_pause_req_d[idx_d] = 1'b1;
      end
      S_TRST: begin
        tgt_pause_req_d[idx_d] = 1'b1;
        tgt_rst_d[idx_d]       = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_INIT;
      idx_q           <= '0;
      cnt_q           <= '0;
      pend_q          <= '0;
      err_q           <= '0;
      tgt_rst_q       <= '1;
      tgt_pause_req_q <= '1;
      dom_pause_ack_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      cnt_q           <= cnt_d;
      pend_q          <= pend_d;
      err_q           <= err_d;
      tgt_rst_q       <= tgt_rst_d;
      tgt_pause_req_q <= tgt_pause_req_d;
      dom_pause_ack_q <= dom_pause_ack_d;
    end
  end

  assign tgt_rst       = tgt_rst_q;
  assign tgt_pause_req = tgt_pause_req_q;
  assign dom_pause_ack = dom_pause_ack_q;
  assign err           = err_q;

endmodule

// File: tb/tb_adam_pause_seq.sv
// Testbench for adam_pause_seq (3 targets, 4-cycle reset, 16-cycle timeout).
// A procedural reference model walks the pause/reset sequences one clock
// edge at a time and predicts every output; the bench compares them on each
// falling edge, alongside directed checks taken from the test plan.
module tb_adam_pause_seq;

  localparam int N  = 3;
  localparam int RC = 4;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         dom_pause_req = 1'b0;
  logic         dom_pause_ack;
  logic [N-1:0] tgt_pause_req;
  logic [N-1:0] tgt_pause_ack = '0;
  logic [N-1:0] tgt_rst_req = '0;
  logic [N-1:0] tgt_rst;
  logic [N-1:0] err;
  logic         err_clr = 1'b0;

  adam_pause_seq #(.NO_TGTS(N), .RST_CYCLES(RC), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .dom_pause_req (dom_pause_req),
    .dom_pause_ack (dom_pause_ack),
    .tgt_pause_req (tgt_pause_req),
    .tgt_pause_ack (tgt_pause_ack),
    .tgt_rst_req   (tgt_rst_req),
    .tgt_rst       (tgt_rst),
    .err           (err),
    .err_clr       (err_clr)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, got, exp, $time);
  endtask

  // ---------------- target responders ----------------
  int           dly  [N] = '{default: 2};
  bit           dead [N] = '{default: 1'b0};
  logic [N-1:0] hist [4] = '{default: '0};

  initial begin
    forever begin
      @(negedge clk);
      for (int s = 3; s > 0; s--) hist[s] = hist[s-1];
      hist[0] = tgt_pause_req;
      for (int i = 0; i < N; i++) begin
        if (!dead[i]) tgt_pause_ack[i] = hist[dly[i]-1][i];
      end
    end
  end

  // ---------------- reference model ----------------
  logic [N-1:0] m_preq, m_rst, m_err, m_pend;
  logic         m_ack;
  bit           aborted;
  logic         s_dom, s_clr;
  logic [N-1:0] s_ack, s_req;

  task automatic m_reset_vals();
    m_preq = '1; m_rst = '1; m_ack = 1'b0; m_err = '0; m_pend = '0;
  endtask

  function automatic logic [N-1:0] bitn(input int i);
    bitn = '0;
    bitn[i] = 1'b1;
  endfunction

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Advance to the next clock edge and capture the inputs it sees.
  task automatic tick();
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      aborted = 1'b1;
      m_reset_vals();
    end else begin
      s_dom = dom_pause_req; s_ack = tgt_pause_ack;
      s_req = tgt_rst_req;   s_clr = err_clr;
    end
  endtask

  // Bookkeeping common to every edge: sticky errors and latched requests.
  task automatic settle(input logic [N-1:0] set, input logic [N-1:0] pclr);
    m_err  = (m_err & ~{N{s_clr}}) | set;
    m_pend = (m_pend & ~pclr) | s_req;
  endtask

  // Returns on the edge where ack[i] reaches lvl, or TO+1 edges in (timeout).
  task automatic wait_lvl(input int i, input logic lvl, output logic to);
    int c = 0;
    bit done = 1'b0;
    to = 1'b0;
    while (!done) begin
      tick();
      if (aborted) done = 1'b1;
      else if (s_ack[i] == lvl) done = 1'b1;
      else if (TO != 0 && c == TO) begin to = 1'b1; done = 1'b1; end
      else begin c++; settle('0, '0); end
    end
  endtask

  // Reset held for RC edges; returns on the last one.
  task automatic hold_rst();
    for (int c = 0; c < RC - 1 && !aborted; c++) begin
      tick();
      if (!aborted) settle('0, '0);
    end
    if (!aborted) tick();
  endtask

  task automatic do_domain();
    logic to;
    int   k;
    bit   leave = 1'b0;
    m_preq = bitn(0); settle('0, '0);
    for (int i = 0; i < N && !aborted; i++) begin
      wait_lvl(i, 1'b1, to);
      if (!aborted) begin
        if (i < N - 1) m_preq[i+1] = 1'b1; else m_ack = 1'b1;
        settle(to ? bitn(i) : '0, '0);
      end
    end
    while (!aborted && !leave) begin
      tick();
      if (!aborted) begin
        if (|m_pend) begin
          k = lowest(m_pend);
          m_rst[k] = 1'b1; settle('0, bitn(k));
          hold_rst();
          if (!aborted) begin m_rst[k] = 1'b0; settle('0, '0); end
        end else if (!s_dom) begin
          m_preq[N-1] = 1'b0; settle('0, '0); leave = 1'b1;
        end else settle('0, '0);
      end
    end
    for (int i = N - 1; i >= 0 && !aborted; i--) begin
      wait_lvl(i, 1'b0, to);
      if (!aborted) begin
        if (i > 0) m_preq[i-1] = 1'b0; else m_ack = 1'b0;
        settle(to ? bitn(i) : '0, '0);
      end
    end
  endtask

  task automatic do_single();
    logic to;
    int   k;
    k = lowest(m_pend);
    m_preq[k] = 1'b1; settle('0, '0);
    wait_lvl(k, 1'b1, to);
    if (aborted) return;
    m_rst[k] = 1'b1; settle(to ? bitn(k) : '0, bitn(k));
    hold_rst();
    if (aborted) return;
    m_rst[k] = 1'b0; m_preq[k] = 1'b0; settle('0, '0);
    wait_lvl(k, 1'b0, to);
    if (aborted) return;
    settle(to ? bitn(k) : '0, '0);
  endtask

  task automatic run_model();
    hold_rst();
    if (aborted) return;
    m_rst = '0; m_preq = '0; settle('0, '0);
    while (!aborted) begin
      tick();
      if (!aborted) begin
        if (s_dom) do_domain();
        else if (|m_pend) do_single();
        else settle('0, '0);
      end
    end
  endtask

  initial begin
    forever begin
      aborted = 1'b0;
      m_reset_vals();
      wait (rst_n === 1'b0);
      wait (rst_n === 1'b1);
      run_model();
    end
  end

  // ---------------- stimulus and checking ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ack(input logic lvl, input int budget, input string tag);
    for (int c = 0; c < budget && dom_pause_ack !== lvl; c++) @(negedge clk);
    check_eq(tag, dom_pause_ack, lvl);
  endtask

  task automatic por_len(input string tag);
    int c = 0;
    while (tgt_rst === 3'b111 && c < 20) begin @(negedge clk); c++; end
    check_eq(tag, c, RC);
    check_eq({tag, "_rst"}, tgt_rst, 3'b000);
    check_eq({tag, "_preq"}, tgt_pause_req, 3'b000);
    check_eq({tag, "_ack"}, dom_pause_ack, 1'b0);
  endtask

  initial begin
    fork
      begin
        forever begin
          @(negedge clk);
          check_eq("mdl_preq", tgt_pause_req, m_preq);
          check_eq("mdl_rst", tgt_rst, m_rst);
          check_eq("mdl_ack", dom_pause_ack, m_ack);
          check_eq("mdl_err", err, m_err);
        end
      end
      begin
        logic [N-1:0] rst_seen, preq_seen;
        int           n_hi;
        bit           ack_low;

        #1 rst_n = 1'b0;
        idle(3);
        check_eq("rst_tgt_rst", tgt_rst, 3'b111);
        check_eq("rst_preq", tgt_pause_req, 3'b111);
        check_eq("rst_ack", dom_pause_ack, 1'b0);
        check_eq("rst_err", err, 3'b000);
        rst_n = 1'b1;
        por_len("por");
        idle(8);

        // Domain pause and resume.
        dom_pause_req = 1'b1;
        wait_ack(1'b1, 100, "pause_ack");
        check_eq("paused_preq", tgt_pause_req, 3'b111);
        dom_pause_req = 1'b0;
        wait_ack(1'b0, 100, "resume_ack");
        check_eq("resumed_preq", tgt_pause_req, 3'b000);
        idle(6);

        // Single-target reset from RUN.
        tgt_rst_req = 3'b010;
        @(negedge clk);
        tgt_rst_req = 3'b000;
        rst_seen = '0; preq_seen = '0; n_hi = 0;
        for (int c = 0; c < 30; c++) begin
          rst_seen |= tgt_rst; preq_seen |= tgt_pause_req;
          if (tgt_rst[1]) n_hi++;
          @(negedge clk);
        end
        check_eq("trst_mask", rst_seen, 3'b010);
        check_eq("trst_preq_mask", preq_seen, 3'b010);
        check_eq("trst_len", n_hi, RC);
        check_eq("trst_done_preq", tgt_pause_req, 3'b000);

        // Reset request colliding with the domain pause rise.
        tgt_rst_req = 3'b100;
        dom_pause_req = 1'b1;
        @(negedge clk);
        tgt_rst_req = 3'b000;
        wait_ack(1'b1, 100, "coll_ack");
        n_hi = 0; ack_low = 1'b0; rst_seen = '0;
        for (int c = 0; c < 15; c++) begin
          if (tgt_rst[2]) n_hi++;
          rst_seen |= tgt_rst;
          if (!dom_pause_ack) ack_low = 1'b1;
          @(negedge clk);
        end
        check_eq("coll_rst_len", n_hi, RC);
        check_eq("coll_rst_mask", rst_seen, 3'b100);
        check_eq("coll_ack_hold", ack_low, 1'b0);
        dom_pause_req = 1'b0;
        wait_ack(1'b0, 100, "coll_resume");
        idle(6);

        // Target 1 never acks: timeout, sticky err, err_clr.
        dead[1] = 1'b1;
        dom_pause_req = 1'b1;
        wait_ack(1'b1, 200, "to_ack");
        check_eq("to_err", err, 3'b010);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
        check_eq("err_clr", err, 3'b000);
        dom_pause_req = 1'b0;
        wait_ack(1'b0, 100, "to_resume");
        dead[1] = 1'b0;
        idle(6);

        // Asynchronous reset in the middle of RESUME.
        dom_pause_req = 1'b1;
        wait_ack(1'b1, 100, "ar_pause");
        dom_pause_req = 1'b0;
        for (int c = 0; c < 50 && tgt_pause_req !== 3'b011; c++) @(negedge clk);
        check_eq("ar_in_resume", tgt_pause_req, 3'b011);
        #2 rst_n = 1'b0;
        #1;
        check_eq("ar_rst", tgt_rst, 3'b111);
        check_eq("ar_preq", tgt_pause_req, 3'b111);
        check_eq("ar_ack", dom_pause_ack, 1'b0);
        idle(2);
        rst_n = 1'b1;
        por_len("ar_por");

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
          @(negedge clk);
          if (c % 60 == 0) begin
            for (int i = 0; i < N; i++) begin
              dly[i]  = $urandom_range(1, 3);
              dead[i] = ($urandom_range(0, 7) == 0);
            end
          end
          if ($urandom_range(0, 15) == 0) dom_pause_req = ~dom_pause_req;
          tgt_rst_req = ($urandom_range(0, 19) == 0) ? N'($urandom) : '0;
          err_clr = ($urandom_range(0, 29) == 0);
        end
        @(negedge clk);
        dom_pause_req = 1'b0; tgt_rst_req = '0; err_clr = 1'b0;
        for (int i = 0; i < N; i++) begin dead[i] = 1'b0; dly[i] = 2; end
        idle(300);
        check_eq("final_ack", dom_pause_ack, 1'b0);
        check_eq("final_preq", tgt_pause_req, 3'b000);
        check_eq("final_rst", tgt_rst, 3'b000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
      end
    join_any
  end

endmodule
